// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage.
// Optional statistics counters are enabled with the PIPE_STAGE_STATS_EN macro.
package pipe_pkg;

  // Occupancy of the stage: nothing held, main entry only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam int STALL_CNT_W = 32;
  localparam int FLUSH_CNT_W = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter used by the optional stage statistics.
module pipe_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  // Count one per cycle while inc is high, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline stage with a 2-entry skid buffer and flush.
// Control fields are zeroed in every invalid slot; data fields are left alone.
// Define PIPE_STAGE_STATS_EN to add stall/bubble/flush statistics counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
`ifdef PIPE_STAGE_STATS_EN
  output logic [DATA_W-1:0] out_data,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [STALL_CNT_W-1:0] bubble_cnt,
  output logic [FLUSH_CNT_W-1:0] flush_cnt
`else
  output logic [DATA_W-1:0] out_data
`endif
);

  state_t            state_q,   state_d;
  logic [CTRL_W-1:0] mCtrl_q,   mCtrl_d;
  logic [DATA_W-1:0] mData_q,   mData_d;
  logic [CTRL_W-1:0] sCtrl_q,   sCtrl_d;
  logic [DATA_W-1:0] sData_q,   sData_d;
  logic              inReady_q, inReady_d;
  logic              accept;
  logic              drain;

  // The main entry is valid in every state except EMPTY, so out_valid is a pure state decode.
  assign out_valid = (state_q != EMPTY);
  assign out_ctrl  = mCtrl_q;
  assign out_data  = mData_q;
  assign in_ready  = inReady_q;

  assign accept = in_valid & inReady_q;
  assign drain  = out_valid & out_ready;

  // Next-state and entry updates; flush wins over accept/drain and wipes only control fields.
  always_comb begin
    state_d = state_q;
    mCtrl_d = mCtrl_q;
    mData_d = mData_q;
    sCtrl_d = sCtrl_q;
    sData_d = sData_q;

    if (flush) begin
      state_d = EMPTY;
      mCtrl_d = '0;
      sCtrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            mCtrl_d = in_ctrl;
            mData_d = in_data;
          end
        end
        ONE: begin
          if (accept && drain) begin
            mCtrl_d = in_ctrl;
            mData_d = in_data;
          end else if (accept) begin
            state_d = TWO;
            sCtrl_d = in_ctrl;
            sData_d = in_data;
          end else if (drain) begin
            state_d = EMPTY;
            mCtrl_d = '0;
          end
        end
        TWO: begin
          if (drain) begin
            state_d = ONE;
            mCtrl_d = sCtrl_q;
            mData_d = sData_q;
            sCtrl_d = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          mCtrl_d = '0;
          sCtrl_d = '0;
        end
      endcase
    end

    inReady_d = (state_d != TWO);
  end

  // State registers; reset clears everything, including both data fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      mCtrl_q   <= '0;
      mData_q   <= '0;
      sCtrl_q   <= '0;
      sData_q   <= '0;
      inReady_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      mCtrl_q   <= mCtrl_d;
      mData_q   <= mData_d;
      sCtrl_q   <= sCtrl_d;
      sData_q   <= sData_d;
      inReady_q <= inReady_d;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  pipe_sat_counter #(.W(STALL_CNT_W)) uStallCnt (
    .clk (clk),
    .rst (rst),
    .inc (out_valid & ~out_ready),
    .cnt (stall_cnt)
  );

  pipe_sat_counter #(.W(STALL_CNT_W)) uBubbleCnt (
    .clk (clk),
    .rst (rst),
    .inc (~out_valid),
    .cnt (bubble_cnt)
  );

  pipe_sat_counter #(.W(FLUSH_CNT_W)) uFlushCnt (
    .clk (clk),
    .rst (rst),
    .inc (flush),
    .cnt (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid against a queue-based occupancy model.
module tb_pipe_stage_skid;

  localparam int CTRL_W = 16;
  localparam int DATA_W = 256;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;
  logic [15:0] flush_cnt;
  longint      expStall;
  longint      expBubble;
  longint      expFlush;
`endif

  entry_t            modelQ[$];
  logic [CTRL_W-1:0] modelDrained[$];
  logic [CTRL_W-1:0] dutDrained[$];
  logic              justReset;
  int                tests = 0;
  int                fails = 0;

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
`ifdef PIPE_STAGE_STATS_EN
    .out_data  (out_data),
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt),
    .flush_cnt (flush_cnt)
`else
    .out_data  (out_data)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] randData();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Compare DUT outputs against the model's view of the stage contents.
  task automatic checkOutput(input string tag);
    logic              expV;
    logic [CTRL_W-1:0] expC;
    logic              expR;
    expV = (modelQ.size() > 0);
    expC = expV ? modelQ[0].ctrl : '0;
    expR = (modelQ.size() < 2);
    tests++;
    assert (out_valid === expV) else begin
      fails++;
      $error("FAIL %s out_valid got %0b want %0b", tag, out_valid, expV);
    end
    tests++;
    assert (out_ctrl === expC) else begin
      fails++;
      $error("FAIL %s out_ctrl got %h want %h", tag, out_ctrl, expC);
    end
    tests++;
    assert (in_ready === expR) else begin
      fails++;
      $error("FAIL %s in_ready got %0b want %0b", tag, in_ready, expR);
    end
    if (expV) begin
      tests++;
      assert (out_data === modelQ[0].data) else begin
        fails++;
        $error("FAIL %s out_data got %h want %h", tag, out_data[63:0], modelQ[0].data[63:0]);
      end
    end else if (justReset) begin
      tests++;
      assert (out_data === '0) else begin
        fails++;
        $error("FAIL %s out_data after reset got %h want 0", tag, out_data[63:0]);
      end
    end
`ifdef PIPE_STAGE_STATS_EN
    tests++;
    assert (stall_cnt === 32'(expStall)) else begin
      fails++;
      $error("FAIL %s stall_cnt got %0d want %0d", tag, stall_cnt, expStall);
    end
    tests++;
    assert (bubble_cnt === 32'(expBubble)) else begin
      fails++;
      $error("FAIL %s bubble_cnt got %0d want %0d", tag, bubble_cnt, expBubble);
    end
    tests++;
    assert (flush_cnt === 16'(expFlush)) else begin
      fails++;
      $error("FAIL %s flush_cnt got %0d want %0d", tag, flush_cnt, expFlush);
    end
`endif
  endtask

  // Drive one cycle of inputs, advance the model by the stage's rules, then check.
  task automatic applyStimulus(input logic r, input logic v, input logic [CTRL_W-1:0] c,
                               input logic [DATA_W-1:0] d, input logic f, input logic o,
                               input string tag);
    logic acc;
    logic drn;
    entry_t e;
    rst       = r;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    flush     = f;
    out_ready = o;
    if (!r && out_valid && o) dutDrained.push_back(out_ctrl);
    if (r) begin
      modelQ.delete();
      justReset = 1'b1;
`ifdef PIPE_STAGE_STATS_EN
      expStall = 0; expBubble = 0; expFlush = 0;
`endif
    end else begin
`ifdef PIPE_STAGE_STATS_EN
      if (modelQ.size() > 0 && !o && expStall < 64'hFFFF_FFFF) expStall++;
      if (modelQ.size() == 0 && expBubble < 64'hFFFF_FFFF) expBubble++;
      if (f && expFlush < 64'hFFFF) expFlush++;
`endif
      acc = v && (modelQ.size() < 2);
      drn = (modelQ.size() > 0) && o;
      if (drn) modelDrained.push_back(modelQ[0].ctrl);
      if (f) begin
        modelQ.delete();
      end else begin
        if (drn) void'(modelQ.pop_front());
        if (acc) begin
          e.ctrl = c;
          e.data = d;
          modelQ.push_back(e);
        end
        if (acc) justReset = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput(tag);
  endtask

  initial begin
    logic [CTRL_W-1:0] zc;
    logic [DATA_W-1:0] zd;
    int drainedBefore;
    zc = '0;
    zd = '0;
    justReset = 1'b1;
`ifdef PIPE_STAGE_STATS_EN
    expStall = 0; expBubble = 0; expFlush = 0;
`endif
    rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0; flush = 1'b0; out_ready = 1'b0;

    // Reset
    applyStimulus(1, 0, zc, zd, 0, 0, "reset0");
    applyStimulus(1, 0, zc, zd, 0, 0, "reset1");
    applyStimulus(0, 0, zc, zd, 0, 1, "idle");

    // Streaming at full throughput
    for (int i = 1; i <= 8; i++)
      applyStimulus(0, 1, CTRL_W'(i), randData(), 0, 1, "stream");
    applyStimulus(0, 0, zc, zd, 0, 1, "streamTail");
    applyStimulus(0, 0, zc, zd, 0, 1, "streamEmpty");

    // Stall and skid
    applyStimulus(0, 1, 16'h00AA, randData(), 0, 0, "skidA");
    applyStimulus(0, 1, 16'h00BB, randData(), 0, 0, "skidB");
    applyStimulus(0, 1, 16'h00DD, randData(), 0, 0, "skidHold1");
    applyStimulus(0, 0, zc, zd, 0, 0, "skidHold2");
    applyStimulus(0, 0, zc, zd, 0, 1, "skidDrainA");
    applyStimulus(0, 0, zc, zd, 0, 1, "skidDrainB");

    // Flush while full, with a valid instruction arriving
    applyStimulus(0, 1, 16'h0011, randData(), 0, 0, "fillM");
    applyStimulus(0, 1, 16'h0022, randData(), 0, 0, "fillS");
    applyStimulus(0, 1, 16'h00CC, randData(), 1, 0, "flushTwo");
    applyStimulus(0, 0, zc, zd, 0, 1, "postFlush");

    // Flush coinciding with a drain from ONE
    applyStimulus(0, 1, 16'h0033, randData(), 0, 0, "oneFill");
    drainedBefore = modelDrained.size();
    applyStimulus(0, 0, zc, zd, 1, 1, "flushDrain");
    tests++;
    assert (modelDrained.size() - drainedBefore == 1 && dutDrained.size() == modelDrained.size()) else begin
      fails++;
      $error("FAIL flushDrainCount got %0d want %0d", dutDrained.size(), modelDrained.size());
    end
    applyStimulus(0, 0, zc, zd, 0, 1, "afterFlushDrain");

    // Reset in TWO with flush also asserted
    applyStimulus(0, 1, 16'h0044, randData(), 0, 0, "rstFillM");
    applyStimulus(0, 1, 16'h0055, randData(), 0, 0, "rstFillS");
    applyStimulus(1, 1, 16'h0066, randData(), 1, 1, "rstInTwo");
    applyStimulus(0, 0, zc, zd, 0, 0, "afterRst");

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 97) == 0, ($urandom % 4) != 0, CTRL_W'($urandom),
                    randData(), ($urandom % 16) == 0, ($urandom % 3) != 0, "random");
    end

    // Everything the consumer saw, in order, against what the model released
    tests++;
    assert (dutDrained.size() == modelDrained.size()) else begin
      fails++;
      $error("FAIL drainCount got %0d want %0d", dutDrained.size(), modelDrained.size());
    end
    if (dutDrained.size() == modelDrained.size()) begin
      for (int i = 0; i < modelDrained.size(); i++) begin
        tests++;
        assert (dutDrained[i] === modelDrained[i]) else begin
          fails++;
          $error("FAIL drainOrder[%0d] got %h want %h", i, dutDrained[i], modelDrained[i]);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
